fp_to_int_stage: RTL and testbench

//   Pipelined IEEE-754 single-precision to signed 32-bit integer converter.

---
 rtl/fp_to_int_stage.sv | 188 ++++++++++++++++++
 tb/tb_fp_to_int_stage.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/fp_to_int_stage.sv
// ============================================================================
// fp_to_int_stage : two-stage binary32 -> signed int32 converter with
//                   selectable rounding mode, exception flags and valid/ready.
// Revision 1.0
// ============================================================================
`default_nettype none

module fp_to_int_stage #(
  parameter int FP_W  = 32,
  parameter int INT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [FP_W-1:0]  in_fp,
  input  logic [1:0]       in_round,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [INT_W-1:0] out_int,
  output logic [2:0]       out_flags
);

  localparam logic [1:0]  RND_NE  = 2'd0;
  localparam logic [1:0]  RND_TZ  = 2'd1;
  localparam logic [1:0]  RND_DN  = 2'd2;
  localparam logic [1:0]  RND_UP  = 2'd3;
  localparam logic [31:0] INT_MAX = 32'h7FFF_FFFF;
  localparam logic [31:0] INT_MIN = 32'h8000_0000;

  typedef enum logic [2:0] {
    CLS_ZERO   = 3'd0,
    CLS_DENORM = 3'd1,
    CLS_NORMAL = 3'd2,
    CLS_INF    = 3'd3,
    CLS_NAN    = 3'd4
  } fp_class_t;

  logic              alive;
  logic              s1_valid;
  logic              s1_sign;
  logic signed [9:0] s1_exp;
  logic [23:0]       s1_mant;
  fp_class_t         s1_class;
  logic [1:0]        s1_round;

  logic              s2_open;
  logic              accept;

  logic [7:0]        in_exp;
  logic [22:0]       in_frac;
  fp_class_t         in_class;

  logic [55:0]       wide;
  logic [55:0]       shifted;
  logic [31:0]       int_part;
  logic              guard;
  logic              sticky;
  logic              round_up;
  logic [32:0]       mag;
  logic [31:0]       res_int;
  logic [2:0]        res_flags;

  // in_ready is held low until the first clock after reset release
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) alive <= 1'b0;
    else        alive <= 1'b1;
  end

  assign s2_open  = !out_valid || out_ready;
  assign in_ready = alive && (!s1_valid || s2_open);
  assign accept   = in_valid && in_ready;

  always_comb begin
    in_exp  = in_fp[30:23];
    in_frac = in_fp[22:0];
    if (in_exp == 8'd0)
      in_class = (in_frac == 23'd0) ? CLS_ZERO : CLS_DENORM;
    else if (in_exp == 8'hFF)
      in_class = (in_frac == 23'd0) ? CLS_INF : CLS_NAN;
    else
      in_class = CLS_NORMAL;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_sign  <= 1'b0;
      s1_exp   <= '0;
      s1_mant  <= '0;
      s1_class <= CLS_ZERO;
      s1_round <= RND_NE;
    end else if (accept) begin
      s1_valid <= 1'b1;
      s1_sign  <= in_fp[31];
      s1_exp   <= $signed({2'b00, in_exp}) - 10'sd127;
      s1_mant  <= {in_exp != 8'd0, in_frac};
      s1_class <= in_class;
      s1_round <= in_round;
    end else if (s2_open) begin
      s1_valid <= 1'b0;
    end
  end

  // Mantissa is placed with 24 fraction bits below the integer field so that
  // every right shift up to 23 keeps all dropped bits for guard/sticky.
  always_comb begin
    wide      = {8'd0, s1_mant, 24'd0};
    shifted   = '0;
    round_up  = 1'b0;
    res_int   = '0;
    res_flags = '0;

    if (s1_exp >= 10'sd0 && s1_exp <= 10'sd23)
      shifted = wide >> (10'sd23 - s1_exp);
    else if (s1_exp > 10'sd23)
      shifted = wide << (s1_exp - 10'sd23);

    int_part = shifted[55:24];
    guard    = shifted[23];
    sticky   = |shifted[22:0];

    // |x| < 1: only the half-point bit (e == -1) can be a guard bit
    if (s1_class == CLS_DENORM || (s1_class == CLS_NORMAL && s1_exp < 10'sd0)) begin
      int_part = '0;
      guard    = (s1_class == CLS_NORMAL) && (s1_exp == -10'sd1);
      sticky   = !guard || (|s1_mant[22:0]);
    end

    case (s1_round)
      RND_NE:  round_up = guard && (sticky || int_part[0]);
      RND_TZ:  round_up = 1'b0;
      RND_DN:  round_up = s1_sign && (guard || sticky);
      RND_UP:  round_up = !s1_sign && (guard || sticky);
      default: round_up = 1'b0;
    endcase

    mag = {1'b0, int_part} + {32'd0, round_up};

    case (s1_class)
      CLS_ZERO: begin
        res_int   = '0;
        res_flags = 3'b000;
      end
      CLS_NAN: begin
        res_int   = INT_MIN;
        res_flags = 3'b100;
      end
      CLS_INF: begin
        res_int   = s1_sign ? INT_MIN : INT_MAX;
        res_flags = 3'b010;
      end
      default: begin
        if (s1_class == CLS_NORMAL && s1_exp >= 10'sd31) begin
          res_int = s1_sign ? INT_MIN : INT_MAX;
          if (s1_sign && s1_exp == 10'sd31 && s1_mant == 24'h80_0000)
            res_flags = 3'b000;
          else
            res_flags = 3'b010;
        end else if ((!s1_sign && mag > {1'b0, INT_MAX}) ||
                     (s1_sign && mag > {1'b0, INT_MIN})) begin
          res_int   = s1_sign ? INT_MIN : INT_MAX;
          res_flags = 3'b010;
        end else begin
          res_int   = s1_sign ? (~mag[31:0] + 32'd1) : mag[31:0];
          res_flags = {2'b00, guard || sticky};
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_int   <= '0;
      out_flags <= '0;
    end else if (s2_open) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_int   <= res_int;
        out_flags <= res_flags;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fp_to_int_stage.sv
// ============================================================================
// tb_fp_to_int_stage : scoreboard bench for fp_to_int_stage.
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_fp_to_int_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_fp = '0;
  logic [1:0]  in_round = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_int;
  logic [2:0]  out_flags;

  fp_to_int_stage #(.FP_W(32), .INT_W(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_fp     (in_fp),
    .in_round  (in_round),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_int   (out_int),
    .out_flags (out_flags)
  );

  always #5 clk = ~clk;

  int          total = 0;
  int          bad = 0;
  logic [34:0] sb[$];
  logic [68:0] vecs[$];
  int          stall = 0;
  bit          saw_block = 1'b0;
  bit          held_valid = 1'b0;
  logic [34:0] held = '0;

  task automatic chk(input string tag, input logic [34:0] got, input logic [34:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // consumer ready: changes only shortly after a rising edge
  always @(posedge clk) begin
    #2;
    if (stall > 0) begin
      out_ready = 1'b0;
      stall--;
    end else begin
      out_ready = 1'b1;
    end
  end

  // output monitor: compares each transferring output against the scoreboard
  always @(negedge clk) begin
    logic [34:0] e;
    if (in_valid && !in_ready && rst_n) saw_block = 1'b1;
    if (held_valid && out_valid) chk("hold", {out_flags, out_int}, held);
    held_valid = 1'b0;
    if (out_valid && !out_ready) begin
      held_valid = 1'b1;
      held = {out_flags, out_int};
    end
    if (out_valid && out_ready) begin
      if (sb.size() == 0) begin
        chk("sb_empty", 35'(sb.size()), 35'd1);
      end else begin
        e = sb.pop_front();
        chk("int", 35'(out_int), 35'(e[31:0]));
        chk("flags", 35'(out_flags), 35'(e[34:32]));
      end
    end
  end

  task automatic send(input logic [31:0] fp, input logic [1:0] rnd,
                      input logic [31:0] res, input logic [2:0] fl);
    int n;
    @(negedge clk);
    in_valid = 1'b1;
    in_fp    = fp;
    in_round = rnd;
    #1;
    n = 0;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (n >= 200) chk("in_ready_timeout", 35'd0, 35'd1);
    else sb.push_back({fl, res});
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() > 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("drain", 35'(sb.size()), 35'd0);
    repeat (2) @(negedge clk);
  endtask

  task automatic latency_check(input logic [31:0] fp, input logic [31:0] res);
    send(fp, 2'd1, res, 3'b000);
    @(negedge clk);
    chk("lat_edge_n1", 35'(out_valid), 35'd0);
    @(negedge clk);
    chk("lat_edge_n2", 35'(out_valid), 35'd1);
  endtask

  initial begin
    // {fp, round, expected int, expected flags}
    vecs.push_back({32'h42FF0000, 2'd0, 32'h00000080, 3'b001});
    vecs.push_back({32'h42FF0000, 2'd1, 32'h0000007F, 3'b001});
    vecs.push_back({32'h3F19999A, 2'd0, 32'h00000001, 3'b001});
    vecs.push_back({32'h3F19999A, 2'd1, 32'h00000000, 3'b001});
    vecs.push_back({32'h3F19999A, 2'd2, 32'h00000000, 3'b001});
    vecs.push_back({32'h3F19999A, 2'd3, 32'h00000001, 3'b001});
    vecs.push_back({32'hC0200000, 2'd0, 32'hFFFFFFFE, 3'b001});
    vecs.push_back({32'hC0200000, 2'd1, 32'hFFFFFFFE, 3'b001});
    vecs.push_back({32'hC0200000, 2'd2, 32'hFFFFFFFD, 3'b001});
    vecs.push_back({32'hC0200000, 2'd3, 32'hFFFFFFFE, 3'b001});
    vecs.push_back({32'h7FC00000, 2'd0, 32'h80000000, 3'b100});
    vecs.push_back({32'h4F32D05E, 2'd0, 32'h7FFFFFFF, 3'b010});
    vecs.push_back({32'hCF000000, 2'd0, 32'h80000000, 3'b000});
    vecs.push_back({32'hCF000001, 2'd0, 32'h80000000, 3'b010});
    vecs.push_back({32'h80000000, 2'd0, 32'h00000000, 3'b000});
    vecs.push_back({32'h3F000000, 2'd0, 32'h00000000, 3'b001});
    vecs.push_back({32'h3FC00000, 2'd0, 32'h00000002, 3'b001});
    vecs.push_back({32'h40200000, 2'd0, 32'h00000002, 3'b001});
    vecs.push_back({32'h00000001, 2'd3, 32'h00000001, 3'b001});
    vecs.push_back({32'h00000001, 2'd0, 32'h00000000, 3'b001});
    vecs.push_back({32'h80000001, 2'd2, 32'hFFFFFFFF, 3'b001});
    vecs.push_back({32'h7F800000, 2'd1, 32'h7FFFFFFF, 3'b010});
    vecs.push_back({32'hFF800000, 2'd1, 32'h80000000, 3'b010});
    vecs.push_back({32'h4EFFFFFF, 2'd0, 32'h7FFFFF80, 3'b000});
    vecs.push_back({32'hBF800000, 2'd2, 32'hFFFFFFFF, 3'b000});

    #1 rst_n = 1'b0;
    #1;
    chk("rst_in_ready", 35'(in_ready), 35'd0);
    chk("rst_out_valid", 35'(out_valid), 35'd0);
    chk("rst_out_int", 35'(out_int), 35'd0);
    chk("rst_out_flags", 35'(out_flags), 35'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1 chk("rel_in_ready_low", 35'(in_ready), 35'd0);
    @(posedge clk);
    #1 chk("rel_in_ready_high", 35'(in_ready), 35'd1);

    foreach (vecs[i]) send(vecs[i][68:37], vecs[i][36:35], vecs[i][34:3], vecs[i][2:0]);
    drain();

    // backpressure: four back-to-back items against a stalled consumer
    @(negedge clk);
    stall = 5;
    saw_block = 1'b0;
    send(32'h3F800000, 2'd1, 32'd1, 3'b000);
    send(32'h40000000, 2'd1, 32'd2, 3'b000);
    send(32'h40400000, 2'd1, 32'd3, 3'b000);
    send(32'h40800000, 2'd1, 32'd4, 3'b000);
    drain();
    chk("in_ready_dropped", 35'(saw_block), 35'd1);

    latency_check(32'h40A00000, 32'd5);
    drain();

    // reset with two items in flight
    send(32'h40C00000, 2'd1, 32'd6, 3'b000);
    send(32'h40E00000, 2'd1, 32'd7, 3'b000);
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 35'(out_valid), 35'd0);
    chk("midrst_in_ready", 35'(in_ready), 35'd0);
    sb.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("no_stale", 35'(out_valid), 35'd0);
    end
    latency_check(32'h41000000, 32'd8);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
